pipelined_adder: RTL

- Parametrised, pipelined two-operand adder/subtractor with valid/ready handshake on both sides.
- Generalises the 4-bit ripple adder: WIDTH-bit operands split into CHUNK-bit slices, one slice resolved per pipeline stage, carry registered between stages.
- Serves as the arithmetic building block for datapath and accumulator blocks that need a full-rate adder at widths where a single-cycle ripple chain misses timing.

---
 rtl/pipelined_adder_if.sv | 40 ++++
 rtl/pipelined_adder.sv | 123 ++++++++++++
 2 files changed

// File: rtl/pipelined_adder_if.sv
// rtl/pipelined_adder_if.sv - operand/result handshake bundle for pipelined_adder
//
// Carries the input beat (in_valid/in_ready, a, b, cin, sub) and the result
// beat (out_valid/out_ready, sum, cout, plus ovf when PIPELINED_ADDER_OVF_EN
// is defined).
//   master : producer of operands / consumer of results
//   slave  : the adder itself
interface pipelined_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef PIPELINED_ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout
`ifdef PIPELINED_ADDER_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout
`ifdef PIPELINED_ADDER_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - pipelined WIDTH-bit adder/subtractor, one CHUNK slice per stage
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - pipelined_adder_if.slave: in_valid/in_ready/a/b/cin/sub in,
//          out_valid/out_ready/sum/cout out (ovf too when enabled)
// Parameters: WIDTH (multiple of CHUNK), CHUNK; STAGES = WIDTH/CHUNK.
// Optional feature: define PIPELINED_ADDER_OVF_EN to add the registered
// signed-overflow output bus.ovf.
module pipelined_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    pipelined_adder_if.slave bus
);
    localparam int STAGES = WIDTH / CHUNK;

    // Per-stage registers: valid, carry into the next slice, the operands
    // (b already inverted for subtract) and the partial result built so far.
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];

    // What each stage would load this cycle.
    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] src_c;
    logic [WIDTH-1:0]  src_a [STAGES];
    logic [WIDTH-1:0]  src_b [STAGES];
    logic [WIDTH-1:0]  src_s [STAGES];
    logic [STAGES-1:0] nxt_c;
    logic [WIDTH-1:0]  nxt_s [STAGES];

    logic stall;

    // The whole pipe freezes when the final result cannot leave, so bubbles
    // are not squeezed out; the upstream sees this directly as !in_ready.
    assign stall        = v_q[STAGES-1] & ~bus.out_ready;
    assign bus.in_ready = ~stall;

    // Stage 0 takes the beat from the bus. Subtract is a + ~b + ~cin, so the
    // inversion is done once at entry and sub itself need not be carried.
    always_comb begin
        src_v    = '0;
        src_c    = '0;
        src_v[0] = bus.in_valid;
        src_c[0] = bus.cin ^ bus.sub;
        src_a[0] = bus.a;
        src_b[0] = bus.b ^ {WIDTH{bus.sub}};
        src_s[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            src_v[k] = v_q[k-1];
            src_c[k] = c_q[k-1];
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_s[k] = s_q[k-1];
        end
    end

    // Stage k resolves slice k; lower slices ride along unchanged.
    always_comb begin
        logic [CHUNK:0] part;
        part  = '0;
        nxt_c = '0;
        for (int k = 0; k < STAGES; k++) begin
            part = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
                 + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, src_c[k]};
            nxt_s[k]                  = src_s[k];
            nxt_s[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
            nxt_c[k]                  = part[CHUNK];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (!stall) begin
            v_q <= src_v;
            c_q <= nxt_c;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= src_a[k];
                b_q[k] <= src_b[k];
                s_q[k] <= nxt_s[k];
            end
        end
    end

    assign bus.out_valid = v_q[STAGES-1];
    assign bus.sum       = s_q[STAGES-1];
    assign bus.cout      = c_q[STAGES-1];

`ifdef PIPELINED_ADDER_OVF_EN
    // Carry into the MSB is recovered from the MSB sum bit (a ^ b' ^ cin_msb);
    // XOR with the carry out gives signed overflow. Only the last stage sees
    // the MSB slice, so one extra flop suffices.
    logic ovf_q;
    logic ovf_nxt;

    assign ovf_nxt = src_a[STAGES-1][WIDTH-1] ^ src_b[STAGES-1][WIDTH-1]
                   ^ nxt_s[STAGES-1][WIDTH-1] ^ nxt_c[STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (!stall) begin
            ovf_q <= ovf_nxt;
        end
    end

    assign bus.ovf = ovf_q;
`endif
endmodule
